// File: rtl/ex_stage_pkg.sv
// Shared opcode, result-class, bus and divider-state definitions
// used by the execute stage and its divider.
package ex_stage_pkg;

  typedef logic [7:0]  aluop_bus_t;
  typedef logic [2:0]  alusel_bus_t;
  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0]  reg_addr_bus_t;
  typedef logic [63:0] double_reg_bus_t;

  localparam logic     RST_ENABLE    = 1'b1;
  localparam reg_bus_t ZERO_WORD     = 32'h0;
  localparam logic     WRITE_ENABLE  = 1'b1;
  localparam logic     WRITE_DISABLE = 1'b0;
  localparam logic     STALL_YES     = 1'b1;
  localparam logic     STALL_NO      = 1'b0;

  localparam aluop_bus_t EXE_NOP_OP   = 8'b0000_0000;
  localparam aluop_bus_t EXE_AND_OP   = 8'b0010_0100;
  localparam aluop_bus_t EXE_OR_OP    = 8'b0010_0101;
  localparam aluop_bus_t EXE_XOR_OP   = 8'b0010_0110;
  localparam aluop_bus_t EXE_NOR_OP   = 8'b0010_0111;
  localparam aluop_bus_t EXE_SLL_OP   = 8'b0111_1100;
  localparam aluop_bus_t EXE_SRL_OP   = 8'b0000_0010;
  localparam aluop_bus_t EXE_SRA_OP   = 8'b0000_0011;
  localparam aluop_bus_t EXE_MOVZ_OP  = 8'b0000_1010;
  localparam aluop_bus_t EXE_MOVN_OP  = 8'b0000_1011;
  localparam aluop_bus_t EXE_SLT_OP   = 8'b0010_1010;
  localparam aluop_bus_t EXE_SLTU_OP  = 8'b0010_1011;
  localparam aluop_bus_t EXE_ADD_OP   = 8'b0010_0000;
  localparam aluop_bus_t EXE_ADDU_OP  = 8'b0010_0001;
  localparam aluop_bus_t EXE_SUB_OP   = 8'b0010_0010;
  localparam aluop_bus_t EXE_SUBU_OP  = 8'b0010_0011;
  localparam aluop_bus_t EXE_ADDI_OP  = 8'b0101_0101;
  localparam aluop_bus_t EXE_ADDIU_OP = 8'b0101_0110;
  localparam aluop_bus_t EXE_DIV_OP   = 8'b0001_1010;
  localparam aluop_bus_t EXE_DIVU_OP  = 8'b0001_1011;

  localparam alusel_bus_t EXE_RES_NOP   = 3'b000;
  localparam alusel_bus_t EXE_RES_LOGIC = 3'b001;
  localparam alusel_bus_t EXE_RES_SHIFT = 3'b010;
  localparam alusel_bus_t EXE_RES_MOVE  = 3'b011;
  localparam alusel_bus_t EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle,
// {hi,lo} = {remainder,quotient}; divide-by-zero finishes in one step.
import ex_stage_pkg::*;

module ex_stage_div_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic        annul,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  div_state_e    state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   rem, quo, dsor;
  logic          neg_q, neg_r;
  logic          go, dz;
  logic [32:0]   shifted;
  logic          take;
  logic [31:0]   diff;
  logic [31:0]   q_fix, r_fix;

  assign go      = start && !annul;
  assign dz      = (divisor == 32'h0);
  assign shifted = {rem, quo[31]};
  assign take    = (shifted >= {1'b0, dsor});
  assign diff    = shifted[31:0] - dsor;
  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem : rem;
  assign result  = {r_fix, q_fix};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nx;
  end

  // Next state plus busy/ready; a flush overrides everything
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    ready    = 1'b0;
    unique case (state)
      DIV_IDLE: begin
        if (go) begin
          busy     = 1'b1;
          state_nx = dz ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DIV_DONE;
      end
      DIV_DONE: begin
        ready    = 1'b1;
        state_nx = DIV_IDLE;
      end
      default: state_nx = DIV_IDLE;
    endcase
    if (annul) begin
      state_nx = DIV_IDLE;
      busy     = 1'b0;
      ready    = 1'b0;
    end
  end

  // Operand latch on start, then one restoring step per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dsor  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == DIV_IDLE && go) begin
      cnt   <= '0;
      dsor  <= (signed_op && divisor[31]) ? -divisor : divisor;
      neg_q <= signed_op && !dz && (dividend[31] ^ divisor[31]);
      neg_r <= signed_op && !dz && dividend[31];
      if (dz) begin
        rem <= dividend;
        quo <= '1;
      end else begin
        rem <= '0;
        quo <= (signed_op && dividend[31]) ? -dividend : dividend;
      end
    end else if (state == DIV_BUSY && !annul) begin
      cnt <= cnt + 1'b1;
      rem <= take ? diff : shifted[31:0];
      quo <= {quo[30:0], take};
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus stalling iterative divider.
// Optional EX_OVERFLOW_TRAP_EN adds signed add/sub overflow trap.
import ex_stage_pkg::*;

module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        wreg_i,
  input  logic [4:0]  wd_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
`ifdef EX_OVERFLOW_TRAP_EN
  ,
  output logic        ovassert_o
`endif
);

  logic [31:0] logic_res, shift_res, arith_res, res;
  logic [31:0] b_eff, sum;
  logic        is_sub, div_start, div_signed;
  logic        div_ready, div_busy, ovf;
  logic [63:0] div_res;

  assign is_sub = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
  assign b_eff  = is_sub ? ~reg2_i + 32'd1 : reg2_i;
  assign sum    = reg1_i + b_eff;

`ifdef EX_OVERFLOW_TRAP_EN
  assign ovf = ((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP) ||
                (aluop_i == EXE_SUB_OP)) &&
               (reg1_i[31] == b_eff[31]) && (sum[31] != reg1_i[31]);
  assign ovassert_o = !rst && ovf;
`else
  assign ovf = 1'b0;
`endif

  // Logic ops
  always_comb begin
    logic_res = ZERO_WORD;
    unique case (1'b1)
      (aluop_i == EXE_AND_OP): logic_res = reg1_i & reg2_i;
      (aluop_i == EXE_OR_OP):  logic_res = reg1_i | reg2_i;
      (aluop_i == EXE_XOR_OP): logic_res = reg1_i ^ reg2_i;
      (aluop_i == EXE_NOR_OP): logic_res = ~(reg1_i | reg2_i);
      default:                 logic_res = ZERO_WORD;
    endcase
  end

  // Shifts: reg2 is the value, reg1[4:0] the amount
  always_comb begin
    shift_res = ZERO_WORD;
    unique case (1'b1)
      (aluop_i == EXE_SLL_OP): shift_res = reg2_i << reg1_i[4:0];
      (aluop_i == EXE_SRL_OP): shift_res = reg2_i >> reg1_i[4:0];
      (aluop_i == EXE_SRA_OP):
        shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      default:                 shift_res = ZERO_WORD;
    endcase
  end

  // Add/sub wrap; slt/sltu compare
  always_comb begin
    arith_res = ZERO_WORD;
    unique case (1'b1)
      (aluop_i == EXE_SLT_OP):
        arith_res = {31'h0, $signed(reg1_i) < $signed(reg2_i)};
      (aluop_i == EXE_SLTU_OP):
        arith_res = {31'h0, reg1_i < reg2_i};
      (aluop_i == EXE_ADD_OP),
      (aluop_i == EXE_ADDU_OP),
      (aluop_i == EXE_ADDI_OP),
      (aluop_i == EXE_ADDIU_OP),
      (aluop_i == EXE_SUB_OP),
      (aluop_i == EXE_SUBU_OP): arith_res = sum;
      default:                  arith_res = ZERO_WORD;
    endcase
  end

  // Result class select
  always_comb begin
    res = ZERO_WORD;
    unique case (alusel_i)
      EXE_RES_LOGIC: res = logic_res;
      EXE_RES_SHIFT: res = shift_res;
      EXE_RES_MOVE:  res = reg1_i;
      EXE_RES_ARITH: res = arith_res;
      default:       res = ZERO_WORD;
    endcase
  end

  assign div_start  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign div_signed = (aluop_i == EXE_DIV_OP);

  ex_stage_div_unit #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (div_signed),
    .annul     (annul_i),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .result    (div_res),
    .ready     (div_ready),
    .busy      (div_busy)
  );

  assign wd_o       = rst ? 5'd0 : wd_i;
  assign wreg_o     = (rst || annul_i || ovf) ? WRITE_DISABLE : wreg_i;
  assign wdata_o    = rst ? ZERO_WORD : res;
  assign whilo_o    = !rst && div_ready;
  assign hi_o       = whilo_o ? div_res[63:32] : ZERO_WORD;
  assign lo_o       = whilo_o ? div_res[31:0] : ZERO_WORD;
  assign stallreq_o = rst ? STALL_NO : div_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vectors, divides, div-by-zero,
// flush and reset mid-divide, optional overflow trap.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic        wreg_i;
  logic [4:0]  wd_i;
  logic        annul_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;
`ifdef EX_OVERFLOW_TRAP_EN
  logic        ovassert_o;
`endif

  int pass_cnt = 0;
  int total    = 0;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wreg_i     (wreg_i),
    .wd_i       (wd_i),
    .annul_i    (annul_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
`ifdef EX_OVERFLOW_TRAP_EN
    ,
    .ovassert_o (ovassert_o)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [2:0] RS_NOP   = 3'b000;
  localparam logic [2:0] RS_LOGIC = 3'b001;
  localparam logic [2:0] RS_SHIFT = 3'b010;
  localparam logic [2:0] RS_ARITH = 3'b100;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic wr, input logic [4:0] wd);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wreg_i   = wr;
    wd_i     = wd;
  endtask

  initial begin
    rst     = 1'b1;
    annul_i = 1'b0;
    drive(OP_OR, RS_LOGIC, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 5'd5);
    tick();
    #1;
    chk("reset_outs",
        {27'h0, wd_o, wreg_o, whilo_o, stallreq_o, wdata_o},
        64'h0);
    chk("reset_hilo", {hi_o, lo_o}, 64'h0);

    tick();
    rst = 1'b0;
    drive(OP_OR, RS_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000, 1'b1, 5'd5);
    #1;
    chk("or_wdata", {32'h0, wdata_o}, {32'h0, 32'h0F0F_F0F0});
    chk("or_ctl", {59'h0, wd_o, wreg_o, stallreq_o, whilo_o},
        {59'h0, 5'd5, 1'b1, 1'b0, 1'b0});

    tick();
    drive(OP_SRA, RS_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd6);
    #1;
    chk("sra", {32'h0, wdata_o}, {32'h0, 32'hF800_0000});

    tick();
    drive(OP_SLTU, RS_ARITH, 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd7);
    #1;
    chk("sltu", {32'h0, wdata_o}, 64'd1);

    tick();
    drive(OP_SUBU, RS_ARITH, 32'd0, 32'd1, 1'b1, 5'd8);
    #1;
    chk("subu_wrap", {32'h0, wdata_o}, {32'h0, 32'hFFFF_FFFF});

    tick();
    drive(OP_OR, 3'b111, 32'h1234, 32'h5678, 1'b1, 5'd9);
    #1;
    chk("bad_sel", {32'h0, wdata_o}, 64'h0);

`ifdef EX_OVERFLOW_TRAP_EN
    tick();
    drive(OP_ADD, RS_ARITH, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd10);
    #1;
    chk("add_ovf", {62'h0, wreg_o, ovassert_o}, {62'h0, 1'b0, 1'b1});
    tick();
    drive(OP_ADDU, RS_ARITH, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd10);
    #1;
    chk("addu_noovf", {wdata_o, 30'h0, wreg_o, ovassert_o},
        {32'h8000_0000, 30'h0, 1'b1, 1'b0});
`else
    tick();
    drive(OP_ADD, RS_ARITH, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd10);
    #1;
    chk("add_wrap", {wdata_o, 31'h0, wreg_o},
        {32'h8000_0000, 31'h0, 1'b1});
`endif

    // DIV -7 / 2, operand changes while busy must be ignored
    tick();
    drive(OP_DIV, RS_NOP, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd0);
    #1;
    chk("div_c0_stall", {62'h0, stallreq_o, whilo_o}, {62'h0, 2'b10});
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c == 5) begin
        reg1_i = 32'd99;
        reg2_i = 32'd5;
      end
      #1;
      chk($sformatf("div_busy_c%0d", c),
          {62'h0, stallreq_o, whilo_o}, {62'h0, 2'b10});
    end
    tick();
    #1;
    chk("div_c33_ctl", {62'h0, stallreq_o, whilo_o}, {62'h0, 2'b01});
    chk("div_c33_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // back-to-back DIVU 100 / 7
    tick();
    drive(OP_DIVU, RS_NOP, 32'd100, 32'd7, 1'b0, 5'd0);
    #1;
    chk("divu_c0_stall", {62'h0, stallreq_o, whilo_o}, {62'h0, 2'b10});
    for (int c = 1; c <= 32; c++) begin
      tick();
      #1;
      chk($sformatf("divu_busy_c%0d", c),
          {62'h0, stallreq_o, whilo_o}, {62'h0, 2'b10});
    end
    tick();
    #1;
    chk("divu_c33_ctl", {62'h0, stallreq_o, whilo_o}, {62'h0, 2'b01});
    chk("divu_c33_hilo", {hi_o, lo_o}, {32'd2, 32'd14});

    tick();
    drive(OP_NOP, RS_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    #1;
    chk("after_div_idle", {hi_o, lo_o[31:2], stallreq_o, whilo_o},
        64'h0);

    // DIVU by zero
    tick();
    drive(OP_DIVU, RS_NOP, 32'h1234, 32'h0, 1'b0, 5'd0);
    #1;
    chk("dz_c0_stall", {62'h0, stallreq_o, whilo_o}, {62'h0, 2'b10});
    tick();
    #1;
    chk("dz_c1_ctl", {62'h0, stallreq_o, whilo_o}, {62'h0, 2'b01});
    chk("dz_c1_hilo", {hi_o, lo_o}, {32'h1234, 32'hFFFF_FFFF});

    // DIV flushed at cycle 10
    tick();
    drive(OP_DIV, RS_NOP, 32'd100, 32'd3, 1'b0, 5'd0);
    for (int c = 1; c < 10; c++) tick();
    tick();
    annul_i = 1'b1;
    drive(OP_NOP, RS_NOP, 32'h0, 32'h0, 1'b1, 5'd3);
    #1;
    chk("annul_c10", {61'h0, stallreq_o, whilo_o, wreg_o}, 64'h0);
    tick();
    annul_i = 1'b0;
    wreg_i  = 1'b0;
    #1;
    chk("annul_c11_idle", {62'h0, stallreq_o, whilo_o}, 64'h0);
    for (int c = 12; c <= 36; c++) begin
      tick();
      #1;
      chk($sformatf("annul_quiet_c%0d", c),
          {hi_o, lo_o[31:2], stallreq_o, whilo_o}, 64'h0);
    end

    // DIV interrupted by reset at cycle 10
    tick();
    drive(OP_DIV, RS_NOP, 32'd100, 32'd3, 1'b0, 5'd0);
    for (int c = 1; c < 10; c++) tick();
    tick();
    rst = 1'b1;
    drive(OP_OR, RS_LOGIC, 32'h00FF, 32'hFF00, 1'b1, 5'd12);
    tick();
    #1;
    chk("rst_mid_outs",
        {27'h0, wd_o, wreg_o, whilo_o, stallreq_o, wdata_o},
        64'h0);
    chk("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
    rst = 1'b0;
    drive(OP_NOP, RS_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    for (int c = 0; c < 25; c++) begin
      tick();
      #1;
      chk($sformatf("rst_quiet_%0d", c),
          {hi_o, lo_o[31:2], stallreq_o, whilo_o}, 64'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
